bf_out_crossbar: RTL and testbench
==================================

# bf_out_crossbar

Parametrised output permutation network for the NTT butterfly array. It routes the upper/lower results of `NUM_BF` butterflies onto `2*NUM_BF` memory-bank write lanes. Per-lane select codes are issued alongside the butterfly operands; an internal delay line re-aligns them with the butterfly outputs `SEL_DELAY` cycles later. Outputs are registered, tagged with a valid, and checked for permutation errors. Sits between the butterfly array and the bank write-back logic.

## Interface
- `DATA_WIDTH`, 12, coefficient width.
- `NUM_BF`, 2, number of butterflies; legal values 1, 2, 4, 8.
- `SEL_DELAY`, 13, butterfly pipeline latency in cycles, ≥1.
- `SELW`, derived = max(1, clog2(2*NUM_BF)), select-code width; not overridable.
- `clk` in 1: single clock, all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `sel_valid` in 1: a select set is issued this cycle.
- `sel` in `2*NUM_BF*SELW`: lane j select at bits `[j*SELW +: SELW]`.
- `bf_upper` in `NUM_BF*DATA_WIDTH`: butterfly b upper result at `[b*DATA_WIDTH +: DATA_WIDTH]`.
- `bf_lower` in `NUM_BF*DATA_WIDTH`: butterfly b lower result, same packing.
- `bf_valid` in 1: butterfly outputs are valid this cycle.
- `err_clr` in 1: clears the sticky error flags.
- `dout` out `2*NUM_BF*DATA_WIDTH`: lane j at `[j*DATA_WIDTH +: DATA_WIDTH]`.
- `dout_valid` out 1: `dout` holds a new routed set.
- `err_conflict` out 1: sticky; two lanes selected the same source.
- `err_align` out 1: sticky; `bf_valid` disagreed with the delayed `sel_valid`.

## Operation
- Source code s selects butterfly b = s>>1.
  - s[0]=0 selects `bf_lower[b]`; s[0]=1 selects `bf_upper[b]`.
  - Codes 0..2*NUM_BF-1 are all legal.
- Delay line: {`sel_valid`, `sel`} enters a `SEL_DELAY`-deep shift register every cycle, unconditionally. The tap output is {dv, ds}.
- Route cycle: the cycle in which dv=1.
  - Lane j takes the source selected by ds[j].
  - The result is registered into `dout`, and `dout_valid`=1 on the next cycle.
- When dv=0: `dout` holds its previous value and `dout_valid`=0.
- Conflict check: in a route cycle, any two lanes with equal ds codes set `err_conflict`. Routing still proceeds, so duplicated data is output.
- Align check: `bf_valid` != dv in any cycle sets `err_align`. Routing follows dv only; `bf_valid` never gates routing.
- Error flags are sticky until `err_clr` or `rst`. If `err_clr` and a new error occur in the same cycle, the new error wins and the flag stays 1.

## Timing
- Latency: `sel` issued at cycle t is applied to butterfly data at cycle t+`SEL_DELAY`. The matching `dout`/`dout_valid` appear at cycle t+`SEL_DELAY`+1.
- Throughput: one select set per cycle, back-to-back, no bubbles required.
- Reset values: delay line all zero (valid bits 0), `dout`=0, `dout_valid`=0, `err_conflict`=0, `err_align`=0.
- Reset mid-operation: all in-flight selects are discarded. No `dout_valid` pulse occurs for sets issued before `rst`.
- After reset deasserts at cycle r, the earliest `dout_valid` is at r+`SEL_DELAY`+1.
- `sel_valid`=0 cycles propagate as bubbles. `sel` contents are don't-care on bubble cycles.
- No backpressure; the downstream is always ready.

## Structure
- Shared package `ntt_net_pkg`:
  - `sel_width(n)` function.
  - Source-code encoding constants `SRC_LOWER`=0 and `SRC_UPPER`=1 (LSB meaning).
  - Legal `NUM_BF` check used in an elaboration-time assertion.
- Sub-module `ntt_shift_n`: parametrised (width, depth) synchronous-reset shift register, instantiated once for {valid, sel}. It is reused by other pipeline-alignment paths.
- Top level holds:
  - the generate loop of per-lane `2*NUM_BF`:1 muxes,
  - the output register,
  - the pairwise conflict comparator (`NUM_BF`=8 → 120 comparisons, single cycle),
  - the error flags.

## Test plan
- Identity, `NUM_BF`=2, `SEL_DELAY`=13: sel={lanes 0..3 = 0,1,2,3} at t=5; at t=18 bf0 lower/upper=0x011/0x022, bf1 lower/upper=0x033/0x044 with `bf_valid`=1. Required: at t=19 `dout`={0x011,0x022,0x033,0x044}, `dout_valid`=1, no errors.
- Reversal, back-to-back: sel={3,2,1,0} then {1,0,3,2} on consecutive cycles. Required: two consecutive `dout_valid` cycles with the correct lane swaps; `dout` holds afterwards with `dout_valid`=0.
- Conflict: sel={0,0,2,3}. Required: `err_conflict` rises in the route cycle and `dout` lanes 0 and 1 both equal the bf0 lower value. After `err_clr`=1 for one cycle, `err_conflict`=0.
- Misalignment: `bf_valid`=1 one cycle early relative to dv. Required: `err_align`=1 and stays 1 through subsequent clean traffic.
- Reset mid-flight: issue 4 sets, assert `rst` at t+3. Required: no `dout_valid` ever for those sets; all outputs 0 after reset.
- Parameter sweep, `NUM_BF`=8, `SEL_DELAY`=1: random permutations with a scoreboard. Required: 1000 sets routed exactly, with latency 2 and no errors.

Source files
------------

// File: rtl/ntt_net_pkg.sv
// Shared definitions for the NTT butterfly routing networks.
//   sel_width()    : select-code width for a network fed by n butterflies
//   num_bf_legal() : supported butterfly counts (elaboration-time check)
//   SRC_LOWER/UPPER: meaning of the select-code LSB
package ntt_net_pkg;

    // Select-code LSB: which half of the butterfly result is taken.
    localparam logic SRC_LOWER = 1'b0;
    localparam logic SRC_UPPER = 1'b1;

    // Each butterfly contributes two sources; never narrower than one bit.
    function automatic int sel_width(input int n);
        int w;
        w = $clog2(2 * n);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit num_bf_legal(input int n);
        return (n == 1) || (n == 2) || (n == 4) || (n == 8);
    endfunction

endpackage

// File: rtl/ntt_shift_n.sv
// Fixed-depth shift register used to re-align side-band data with a
// pipelined datapath. Shifts every cycle; reset clears every stage.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   din  : word entering the line
//   dout : word that entered DEPTH cycles earlier
module ntt_shift_n #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage;

    always_ff @(posedge clk) begin
        if (rst) begin
            stage <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign dout = stage[DEPTH-1];

endmodule

// File: rtl/bf_out_crossbar.sv
// Output permutation network for the NTT butterfly array. Routes the
// lower/upper results of NUM_BF butterflies onto 2*NUM_BF bank write lanes
// using per-lane select codes that are delayed by SEL_DELAY cycles to line
// up with the butterfly pipeline.
//   clk, rst     : clock, synchronous active-high reset
//   sel_valid    : select set issued this cycle
//   sel          : lane j code at [j*SELW +: SELW]; code s -> bf s>>1, s[0]=upper
//   bf_upper/low : butterfly b result at [b*DATA_WIDTH +: DATA_WIDTH]
//   bf_valid     : butterfly outputs valid (checked only, never gates routing)
//   err_clr      : clears sticky error flags
//   dout         : lane j at [j*DATA_WIDTH +: DATA_WIDTH], held between sets
//   dout_valid   : dout updated with a new routed set
//   err_conflict : sticky, two lanes picked the same source
//   err_align    : sticky, bf_valid disagreed with the delayed sel_valid
module bf_out_crossbar
    import ntt_net_pkg::*;
#(
    parameter int DATA_WIDTH = 12,
    parameter int NUM_BF     = 2,
    parameter int SEL_DELAY  = 13
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                sel_valid,
    input  logic [2*NUM_BF*sel_width(NUM_BF)-1:0] sel,
    input  logic [NUM_BF*DATA_WIDTH-1:0]        bf_upper,
    input  logic [NUM_BF*DATA_WIDTH-1:0]        bf_lower,
    input  logic                                bf_valid,
    input  logic                                err_clr,
    output logic [2*NUM_BF*DATA_WIDTH-1:0]      dout,
    output logic                                dout_valid,
    output logic                                err_conflict,
    output logic                                err_align
);

    localparam int SELW  = sel_width(NUM_BF);
    localparam int LANES = 2 * NUM_BF;
    localparam int BW    = (NUM_BF > 1) ? $clog2(NUM_BF) : 1;

    if (!num_bf_legal(NUM_BF)) begin : g_bad_num_bf
        $error("bf_out_crossbar: NUM_BF must be 1, 2, 4 or 8");
    end
    if (SEL_DELAY < 1) begin : g_bad_delay
        $error("bf_out_crossbar: SEL_DELAY must be at least 1");
    end

    // Delayed select set: dv marks the route cycle.
    logic                       dv;
    logic [LANES-1:0][SELW-1:0] ds;
    logic [LANES*SELW:0]        tap;

    ntt_shift_n #(
        .WIDTH(LANES * SELW + 1),
        .DEPTH(SEL_DELAY)
    ) u_sel_dly (
        .clk  (clk),
        .rst  (rst),
        .din  ({sel_valid, sel}),
        .dout (tap)
    );

    assign {dv, ds} = tap;

    logic [NUM_BF-1:0][DATA_WIDTH-1:0] upper_a;
    logic [NUM_BF-1:0][DATA_WIDTH-1:0] lower_a;
    assign upper_a = bf_upper;
    assign lower_a = bf_lower;

    logic [DATA_WIDTH-1:0] routed [LANES];

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [SELW-1:0] code;
        logic [BW-1:0]   bsel;
        assign code = ds[j];
        if (NUM_BF == 1) begin : g_one
            assign bsel = '0;
        end else begin : g_many
            assign bsel = code[SELW-1:1];
        end
        assign routed[j] = (code[0] == SRC_UPPER) ? upper_a[bsel] : lower_a[bsel];
    end

    // All lane pairs compared in one cycle; duplicates still get routed.
    logic conflict;
    always_comb begin
        conflict = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            for (int k = i + 1; k < LANES; k++) begin
                if (ds[i] == ds[k]) conflict = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout         <= '0;
            dout_valid   <= 1'b0;
            err_conflict <= 1'b0;
            err_align    <= 1'b0;
        end else begin
            dout_valid <= dv;
            if (dv) begin
                for (int j = 0; j < LANES; j++) begin
                    dout[j*DATA_WIDTH +: DATA_WIDTH] <= routed[j];
                end
            end
            // A new error in the clear cycle keeps the flag set.
            err_conflict <= (dv & conflict) | (err_conflict & ~err_clr);
            err_align    <= (bf_valid != dv) | (err_align & ~err_clr);
        end
    end

endmodule

// File: tb/tb_bf_out_crossbar.sv
module tb_bf_out_crossbar;

    localparam int DW = 12;
    localparam int DA = 13;   // instance A: NUM_BF=2, SEL_DELAY=13

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Instance A
    logic        a_sel_valid = 0, a_bf_valid = 0, a_err_clr = 0;
    logic [7:0]  a_sel = '0;
    logic [23:0] a_up = '0, a_lo = '0;
    logic [47:0] a_dout;
    logic        a_dv, a_ec, a_ea;

    bf_out_crossbar #(.DATA_WIDTH(DW), .NUM_BF(2), .SEL_DELAY(DA)) u_a (
        .clk(clk), .rst(rst), .sel_valid(a_sel_valid), .sel(a_sel),
        .bf_upper(a_up), .bf_lower(a_lo), .bf_valid(a_bf_valid),
        .err_clr(a_err_clr), .dout(a_dout), .dout_valid(a_dv),
        .err_conflict(a_ec), .err_align(a_ea));

    // Instance B
    logic         b_sel_valid = 0, b_bf_valid = 0, b_err_clr = 0;
    logic [63:0]  b_sel = '0;
    logic [95:0]  b_up = '0, b_lo = '0;
    logic [191:0] b_dout;
    logic         b_dv, b_ec, b_ea;

    bf_out_crossbar #(.DATA_WIDTH(DW), .NUM_BF(8), .SEL_DELAY(1)) u_b (
        .clk(clk), .rst(rst), .sel_valid(b_sel_valid), .sel(b_sel),
        .bf_upper(b_up), .bf_lower(b_lo), .bf_valid(b_bf_valid),
        .err_clr(b_err_clr), .dout(b_dout), .dout_valid(b_dv),
        .err_conflict(b_ec), .err_align(b_ea));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        string            name;
        logic [3:0][1:0]  sel;   // lane3..lane0
        logic [23:0]      lo;    // {bf1, bf0}
        logic [23:0]      up;
        logic [47:0]      exp;   // lane3..lane0
        logic             conf;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [7:0] s, input logic [23:0] lo,
                                input logic [23:0] up, input logic [47:0] e, input logic c);
        vec_t v;
        v.name = n; v.sel = s; v.lo = lo; v.up = up; v.exp = e; v.conf = c;
        return v;
    endfunction

    // Issue one set, feed matching data SEL_DELAY cycles later, check result and hold.
    task automatic run_vec(input vec_t v, input logic clr, input logic exp_align);
        if (clr) begin
            a_err_clr = 1;
            @(posedge clk); #1;
            a_err_clr = 0;
        end
        a_sel_valid = 1; a_sel = v.sel;
        @(posedge clk); #1;
        a_sel_valid = 0; a_sel = 8'($urandom);
        repeat (DA - 1) @(posedge clk);
        #1;
        a_lo = v.lo; a_up = v.up; a_bf_valid = 1;
        @(posedge clk); #1;
        a_bf_valid = 0; a_lo = 24'($urandom); a_up = 24'($urandom);
        chk({v.name, " dout"}, 192'(a_dout), 192'(v.exp));
        chk({v.name, " valid"}, 192'(a_dv), 192'(1'b1));
        chk({v.name, " conflict"}, 192'(a_ec), 192'(v.conf));
        chk({v.name, " align"}, 192'(a_ea), 192'(exp_align));
        @(posedge clk); #1;
        chk({v.name, " hold"}, 192'(a_dout), 192'(v.exp));
        chk({v.name, " hold valid"}, 192'(a_dv), 192'(1'b0));
    endtask

    function automatic logic [191:0] route8(input logic [63:0] s, input logic [95:0] lo,
                                            input logic [95:0] up);
        logic [191:0] r;
        logic [3:0]   c;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            c = s[j*4 +: 4];
            r[j*12 +: 12] = c[0] ? up[int'(c[3:1])*12 +: 12] : lo[int'(c[3:1])*12 +: 12];
        end
        return r;
    endfunction

    logic [63:0] pm  [1000];
    logic [95:0] lo8 [1000];
    logic [95:0] up8 [1000];

    initial begin
        vec_t vt[6];
        int   nvalid;
        int   p[16];

        // Sources: 0->011 1->022 2->033 3->044
        vt[0] = mk("identity", {2'd3,2'd2,2'd1,2'd0}, {12'h033,12'h011}, {12'h044,12'h022},
                   {12'h044,12'h033,12'h022,12'h011}, 1'b0);
        vt[1] = mk("reverse",  {2'd0,2'd1,2'd2,2'd3}, {12'h033,12'h011}, {12'h044,12'h022},
                   {12'h011,12'h022,12'h033,12'h044}, 1'b0);
        vt[2] = mk("pairswap", {2'd2,2'd3,2'd0,2'd1}, {12'h033,12'h011}, {12'h044,12'h022},
                   {12'h033,12'h044,12'h011,12'h022}, 1'b0);
        // Sources: 0->FFF 1->001 2->0AB 3->800
        vt[3] = mk("mixed",    {2'd0,2'd1,2'd3,2'd2}, {12'h0AB,12'hFFF}, {12'h800,12'h001},
                   {12'hFFF,12'h001,12'h800,12'h0AB}, 1'b0);
        vt[4] = mk("conflict", {2'd3,2'd2,2'd0,2'd0}, {12'h033,12'h011}, {12'h044,12'h022},
                   {12'h044,12'h033,12'h011,12'h011}, 1'b1);
        vt[5] = mk("allsame",  {2'd1,2'd1,2'd1,2'd1}, {12'h0AB,12'hFFF}, {12'h800,12'h001},
                   {12'h001,12'h001,12'h001,12'h001}, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        chk("reset dout", 192'(a_dout), 192'(0));
        chk("reset valid", 192'(a_dv), 192'(0));
        chk("reset conflict", 192'(a_ec), 192'(0));
        chk("reset align", 192'(a_ea), 192'(0));

        for (int i = 0; i < 6; i++) run_vec(vt[i], 1'b1, 1'b0);

        // Clearing the conflict left by the last table entry.
        a_err_clr = 1;
        @(posedge clk); #1;
        a_err_clr = 0;
        chk("conflict cleared", 192'(a_ec), 192'(0));

        // Back-to-back: reverse then pairswap, two consecutive valid cycles.
        a_sel_valid = 1; a_sel = vt[1].sel;
        @(posedge clk); #1;
        a_sel = vt[2].sel;
        @(posedge clk); #1;
        a_sel_valid = 0;
        repeat (DA - 2) @(posedge clk);
        #1;
        a_lo = vt[1].lo; a_up = vt[1].up; a_bf_valid = 1;
        @(posedge clk); #1;
        chk("b2b first", 192'(a_dout), 192'(vt[1].exp));
        chk("b2b first valid", 192'(a_dv), 192'(1));
        @(posedge clk); #1;
        a_bf_valid = 0;
        chk("b2b second", 192'(a_dout), 192'(vt[2].exp));
        chk("b2b second valid", 192'(a_dv), 192'(1));
        @(posedge clk); #1;
        chk("b2b hold", 192'(a_dout), 192'(vt[2].exp));
        chk("b2b hold valid", 192'(a_dv), 192'(0));
        chk("b2b align", 192'(a_ea), 192'(0));

        // Misalignment: bf_valid rises one cycle before the route cycle.
        a_sel_valid = 1; a_sel = vt[0].sel;
        @(posedge clk); #1;
        a_sel_valid = 0;
        repeat (DA - 2) @(posedge clk);
        #1;
        a_lo = vt[0].lo; a_up = vt[0].up; a_bf_valid = 1;
        @(posedge clk); #1;
        chk("early align", 192'(a_ea), 192'(1));
        @(posedge clk); #1;
        a_bf_valid = 0;
        chk("early dout", 192'(a_dout), 192'(vt[0].exp));
        run_vec(vt[3], 1'b0, 1'b1);   // clean traffic, flag stays set
        run_vec(vt[3], 1'b1, 1'b0);   // explicit clear

        // Clear and new error in the same cycle: error wins.
        a_err_clr = 1; a_bf_valid = 1;
        @(posedge clk); #1;
        a_err_clr = 0; a_bf_valid = 0;
        chk("clr vs new error", 192'(a_ea), 192'(1));
        a_err_clr = 1;
        @(posedge clk); #1;
        a_err_clr = 0;
        chk("clr after collision", 192'(a_ea), 192'(0));

        // Reset mid-flight: four sets, reset on the fourth issue cycle.
        for (int i = 0; i < 4; i++) begin
            a_sel_valid = 1; a_sel = vt[i].sel;
            if (i == 3) rst = 1;
            @(posedge clk); #1;
        end
        rst = 0; a_sel_valid = 0;
        chk("rst dout", 192'(a_dout), 192'(0));
        chk("rst valid", 192'(a_dv), 192'(0));
        chk("rst flags", 192'({a_ec, a_ea}), 192'(0));
        nvalid = 0;
        for (int i = 0; i < DA + 6; i++) begin
            @(posedge clk); #1;
            if (a_dv) nvalid++;
        end
        chk("rst no valid", 192'(nvalid), 192'(0));
        chk("rst idle dout", 192'(a_dout), 192'(0));

        // NUM_BF=8, SEL_DELAY=1: 1000 random permutations back-to-back.
        for (int n = 0; n < 1000; n++) begin
            for (int i = 0; i < 16; i++) p[i] = i;
            for (int i = 15; i > 0; i--) begin
                int k, t;
                k = int'($urandom_range(i, 0));
                t = p[i]; p[i] = p[k]; p[k] = t;
            end
            for (int i = 0; i < 16; i++) pm[n][i*4 +: 4] = 4'(p[i]);
            lo8[n] = {$urandom, $urandom, $urandom};
            up8[n] = {$urandom, $urandom, $urandom};
        end
        for (int c = 0; c < 1002; c++) begin
            if (c >= 2) begin
                chk($sformatf("sweep set %0d", c - 2), b_dout, route8(pm[c-2], lo8[c-2], up8[c-2]));
                chk($sformatf("sweep valid %0d", c - 2), 192'(b_dv), 192'(1));
            end else if (c == 1) begin
                chk("sweep latency", 192'(b_dv), 192'(0));
            end
            b_sel_valid = (c < 1000);
            b_sel = (c < 1000) ? pm[c] : 64'($urandom);
            b_bf_valid = (c >= 1 && c <= 1000);
            if (c >= 1 && c <= 1000) begin
                b_lo = lo8[c-1]; b_up = up8[c-1];
            end
            @(posedge clk); #1;
        end
        b_sel_valid = 0; b_bf_valid = 0;
        chk("sweep last", b_dout, route8(pm[999], lo8[999], up8[999]));
        @(posedge clk); #1;
        chk("sweep end valid", 192'(b_dv), 192'(0));
        chk("sweep errors", 192'({b_ec, b_ea}), 192'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
